// File: rtl/rr_arbiter_param_if.sv
// Request/grant bundle between N requesting masters and the round-robin arbiter.
// The master drives enable and requests; the arbiter returns a registered one-hot grant.
interface rr_arbiter_param_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic             En;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    modport master (
        output En,
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx
    );

    modport slave (
        input  En,
        input  req,
        output grant,
        output grant_valid,
        output grant_idx
    );
endinterface

// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with owner hold and bounded tenure under contention.
// Grant is registered: one cycle after req is sampled; requests are level-sensitive, no queuing.
module rr_arbiter_param #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_arbiter_param_if.slave  arb
);
    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;

    logic [N-1:0]     others;
    logic [IDX_W-1:0] nxt_start;
    logic [IDX_W-1:0] win_idle;
    logic [IDX_W-1:0] win_busy;

    // First set bit of v scanning circularly from s.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] v, input logic [IDX_W-1:0] s);
        logic found;
        int   j;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(s) + k) % N;
            if (!found && v[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        return IDX_W'((int'(x) + 1) % N);
    endfunction

    assign others    = arb.req & ~grant_q;
    assign nxt_start = wrap_inc(idx_q);
    assign win_idle  = pick(arb.req, ptr_q);
    assign win_busy  = pick(others, nxt_start);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                if (arb.En && (|arb.req)) begin
                    grant_d = ONE << win_idle;
                    idx_d   = win_idle;
                    vld_d   = 1'b1;
                    hold_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!arb.En || (!arb.req[idx_q] && !(|others))) begin
                    grant_d = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    hold_d  = '0;
                    ptr_d   = nxt_start;
                    state_d = ST_IDLE;
                end else if (!arb.req[idx_q] ||
                             ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (|others))) begin
                    // Release or tenure expiry: hand straight over, no bubble cycle.
                    grant_d = ONE << win_busy;
                    idx_d   = win_busy;
                    vld_d   = 1'b1;
                    hold_d  = '0;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
                hold_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // rst_n is active-high here: a 1 at the edge resets the block.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_valid = vld_q;
    assign arb.grant_idx   = idx_q;
endmodule
